// File: rtl/spi_slave_rx.sv
// SPI slave receiver (CPOL 0, CPHA 1, MSB first). The SPI lines are
// oversampled with clk, and each received word is offered on a valid/ready
// holding register. The block also keeps sticky framing and overrun flags.
module spi_slave_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_scl,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_active,
  output logic [7:0]        bytes_in_frame,
  output logic              frame_err,
  output logic              overrun,
  input  logic              err_clr
);

  localparam int unsigned CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 2);

  localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(DATA_W - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;

  logic [SYNC_STAGES-1:0] scl_sync, ss_sync, mosi_sync;
  logic                   scl_d, ss_d;
  logic                   scl_s, ss_s, mosi_s;
  logic                   scl_fall, ss_fall, ss_rise;

  logic [1:0]        state_q, state_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [7:0]        bytes_q, bytes_n;
  logic              word_done_q, word_done_n;
  logic [FLUSH_W-1:0] flush_q, flush_n;
  logic [DATA_W-1:0] rx_data_q, rx_data_n;
  logic              rx_valid_q, rx_valid_n;
  logic              frame_err_q, frame_err_n;
  logic              overrun_q, overrun_n;
  logic              frame_active_q;

  // Input synchronizers plus one delayed copy for edge detection.
  // The SS chain resets to 1 (deselected) so reset produces no edge on it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      scl_d     <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], spi_scl};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      scl_d     <= scl_s;
      ss_d      <= ss_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign scl_fall = scl_d & ~scl_s;
  assign ss_fall  = ss_d & ~ss_s;
  assign ss_rise  = ~ss_d & ss_s;

  // Next-state logic for the frame FSM, the shifter, the holding register
  // and the error flags.
  always_comb begin
    state_n     = state_q;
    shift_n     = shift_q;
    cnt_n       = cnt_q;
    bytes_n     = bytes_q;
    word_done_n = 1'b0;
    flush_n     = flush_q;
    rx_data_n   = rx_data_q;
    rx_valid_n  = rx_valid_q;
    frame_err_n = frame_err_q & ~err_clr;
    overrun_n   = overrun_q & ~err_clr;

    case (state_q)
      // The reset values in the SS chain are not real samples. Wait until the
      // chain has refilled from the pin before trusting ss_s=1, so that a
      // frame already in progress at reset release is never joined.
      WAIT_IDLE: begin
        if (flush_q != FLUSH_DONE) begin
          flush_n = flush_q + FLUSH_W'(1);
        end else if (ss_s) begin
          state_n = IDLE;
        end
      end
      IDLE: begin
        if (ss_fall) begin
          cnt_n   = '0;
          shift_n = '0;
          bytes_n = 8'd0;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        // ss_rise has priority over a falling SCL edge in the same cycle.
        if (ss_rise) begin
          state_n = IDLE;
          if (cnt_q != '0) frame_err_n = 1'b1;
          cnt_n = '0;
        end else if (scl_fall) begin
          shift_n = {shift_q[DATA_W-2:0], mosi_s};
          if (cnt_q == LAST_BIT) begin
            cnt_n       = '0;
            word_done_n = 1'b1;
            if (bytes_q != 8'hFF) bytes_n = bytes_q + 8'd1;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_n = WAIT_IDLE;
    endcase

    // A completed word sits in shift_q for one cycle, then moves to the holding register.
    if (word_done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_n  = shift_q;
        rx_valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_n = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= WAIT_IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      bytes_q        <= 8'd0;
      word_done_q    <= 1'b0;
      flush_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      overrun_q      <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      state_q        <= state_n;
      shift_q        <= shift_n;
      cnt_q          <= cnt_n;
      bytes_q        <= bytes_n;
      word_done_q    <= word_done_n;
      flush_q        <= flush_n;
      rx_data_q      <= rx_data_n;
      rx_valid_q     <= rx_valid_n;
      frame_err_q    <= frame_err_n;
      overrun_q      <= overrun_n;
      frame_active_q <= (state_n == ACTIVE);
    end
  end

  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign frame_active   = frame_active_q;
  assign bytes_in_frame = bytes_q;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx. It applies a table of single frames,
// hand-written corner sequences, and random frames that are checked against
// a bit-stream scoreboard.
module tb_spi_slave_rx;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DATA_W      = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              spi_scl = 1'b0;
  logic              spi_ss = 1'b1;
  logic              spi_mosi = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready = 1'b0;
  logic              frame_active;
  logic [7:0]        bytes_in_frame;
  logic              frame_err;
  logic              overrun;
  logic              err_clr = 1'b0;

  spi_slave_rx #(.SYNC_STAGES(SYNC_STAGES), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .spi_scl(spi_scl), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_active(frame_active), .bytes_in_frame(bytes_in_frame),
    .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int half = 4;

  logic [7:0] expq[$];
  bit mon_en = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic       exp_valid;
    logic       exp_ferr;
    logic [7:0] exp_bytes;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    tick(half);
    spi_scl  = 1'b1;
    spi_mosi = b;
    tick(half);
    spi_scl  = 1'b0;
  endtask

  // Sends the low n bits of val, MSB first, and returns right after the last falling edge.
  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
  endtask

  task automatic frame(input logic [31:0] val, input int n);
    spi_ss = 1'b0;
    send_bits(val, n);
    tick(half);
    spi_ss = 1'b1;
    tick(half + SYNC_STAGES + 6);
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  // Scoreboard: every accepted word must match the next word of the model's stream.
  always @(negedge clk) begin
    if (mon_en && rx_valid && rx_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rand_word: got unexpected word %0h, required none", rx_data);
      end else begin
        check("rand_word", 32'(rx_data), 32'(expq.pop_front()));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] acc;
    int         nacc;
    int         n;
    logic       b;

    vt[0] = '{data: 8'hAB, nbits: 8, exp_valid: 1'b1, exp_ferr: 1'b0, exp_bytes: 8'd1};
    vt[1] = '{data: 8'h5C, nbits: 8, exp_valid: 1'b1, exp_ferr: 1'b0, exp_bytes: 8'd1};
    vt[2] = '{data: 8'hFF, nbits: 8, exp_valid: 1'b1, exp_ferr: 1'b0, exp_bytes: 8'd1};
    vt[3] = '{data: 8'h00, nbits: 8, exp_valid: 1'b1, exp_ferr: 1'b0, exp_bytes: 8'd1};
    vt[4] = '{data: 8'hA8, nbits: 5, exp_valid: 1'b0, exp_ferr: 1'b1, exp_bytes: 8'd0};
    vt[5] = '{data: 8'h80, nbits: 1, exp_valid: 1'b0, exp_ferr: 1'b1, exp_bytes: 8'd0};

    // Reset state
    tick(3);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_frame_active", 32'(frame_active), 32'h0);
    check("rst_bytes", 32'(bytes_in_frame), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rst = 1'b1;
    tick(10);

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      frame(32'(vt[i].data >> (8 - vt[i].nbits)), vt[i].nbits);
      check($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) check($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vt[i].data));
      check($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vt[i].exp_ferr));
      check($sformatf("vec%0d_bytes", i), 32'(bytes_in_frame), 32'(vt[i].exp_bytes));
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'h0);
      check($sformatf("vec%0d_active", i), 32'(frame_active), 32'h0);
      if (vt[i].exp_valid) accept();
      check($sformatf("vec%0d_valid_after", i), 32'(rx_valid), 32'h0);
      clear_err();
      check($sformatf("vec%0d_ferr_cleared", i), 32'(frame_err), 32'h0);
    end

    // Latency: rx_valid rises SYNC_STAGES+2 cycles after the 8th falling edge
    spi_ss = 1'b0;
    tick(half);
    check("active_in_frame", 32'(frame_active), 32'h1);
    send_bits(32'hAB, 8);
    tick(SYNC_STAGES + 1);
    check("latency_before", 32'(rx_valid), 32'h0);
    tick(1);
    check("latency_at", 32'(rx_valid), 32'h1);
    check("latency_data", 32'(rx_data), 32'hAB);
    tick(half);
    spi_ss = 1'b1;
    tick(10);
    accept();

    // Back-to-back words with no consumer: second word dropped as overrun
    spi_ss = 1'b0;
    send_bits(32'hAB, 8);
    send_bits(32'h5C, 8);
    tick(half);
    spi_ss = 1'b1;
    tick(10);
    check("b2b_data", 32'(rx_data), 32'hAB);
    check("b2b_valid", 32'(rx_valid), 32'h1);
    check("b2b_overrun", 32'(overrun), 32'h1);
    check("b2b_bytes", 32'(bytes_in_frame), 32'h2);
    check("b2b_ferr", 32'(frame_err), 32'h0);
    accept();
    check("b2b_valid_after", 32'(rx_valid), 32'h0);
    check("b2b_overrun_held", 32'(overrun), 32'h1);
    clear_err();
    check("b2b_overrun_cleared", 32'(overrun), 32'h0);

    // Handshake collision: accept in the very cycle the second word loads
    spi_ss = 1'b0;
    send_bits(32'h11, 8);
    tick(half + 6);
    check("coll_first_valid", 32'(rx_valid), 32'h1);
    send_bits(32'h22, 8);
    tick(SYNC_STAGES + 1);
    check("coll_still_first", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("coll_valid", 32'(rx_valid), 32'h1);
    check("coll_data", 32'(rx_data), 32'h22);
    check("coll_overrun", 32'(overrun), 32'h0);
    tick(half);
    spi_ss = 1'b1;
    tick(10);
    check("coll_bytes", 32'(bytes_in_frame), 32'h2);
    accept();

    // Reset during the 4th bit of 0xAB, released with SS still low
    spi_ss = 1'b0;
    send_bits(32'h5, 3);
    tick(half);
    spi_scl  = 1'b1;
    spi_mosi = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(half);
    spi_scl = 1'b0;
    send_bits(32'hB, 4);
    tick(half);
    check("rstmid_active", 32'(frame_active), 32'h0);
    check("rstmid_valid_in", 32'(rx_valid), 32'h0);
    spi_ss = 1'b1;
    tick(10);
    check("rstmid_valid", 32'(rx_valid), 32'h0);
    check("rstmid_ferr", 32'(frame_err), 32'h0);
    check("rstmid_bytes", 32'(bytes_in_frame), 32'h0);
    frame(32'h3C, 8);
    check("rstmid_next_valid", 32'(rx_valid), 32'h1);
    check("rstmid_next_data", 32'(rx_data), 32'h3C);
    check("rstmid_next_bytes", 32'(bytes_in_frame), 32'h1);
    accept();

    // SCL toggling while deselected is ignored
    for (int i = 0; i < 8; i++) begin
      tick(half);
      spi_scl  = 1'b1;
      spi_mosi = i[0];
      tick(half);
      spi_scl  = 1'b0;
    end
    tick(10);
    check("sshigh_idle_valid", 32'(rx_valid), 32'h0);
    frame(32'hAB, 8);
    check("sshigh_data", 32'(rx_data), 32'hAB);
    check("sshigh_valid", 32'(rx_valid), 32'h1);
    check("sshigh_bytes", 32'(bytes_in_frame), 32'h1);
    check("sshigh_ferr", 32'(frame_err), 32'h0);
    accept();
    check("sshigh_single_word", 32'(rx_valid), 32'h0);

    // Random frames against a bit-stream model with the consumer always ready
    rx_ready = 1'b1;
    mon_en   = 1'b1;
    for (int f = 0; f < 16; f++) begin
      n = int'($urandom_range(0, 20));
      acc = 8'h00;
      nacc = 0;
      spi_ss = 1'b0;
      for (int k = 0; k < n; k++) begin
        b = 1'($urandom_range(0, 1));
        send_bit(b);
        acc = {acc[6:0], b};
        nacc++;
        if (nacc == 8) begin
          expq.push_back(acc);
          nacc = 0;
        end
      end
      tick(half);
      spi_ss = 1'b1;
      tick(12);
      check($sformatf("rand%0d_ferr", f), 32'(frame_err), 32'((n % 8) != 0));
      check($sformatf("rand%0d_bytes", f), 32'(bytes_in_frame), 32'(n / 8));
      check($sformatf("rand%0d_overrun", f), 32'(overrun), 32'h0);
      clear_err();
    end
    check("rand_queue_empty", 32'(expq.size()), 32'h0);
    mon_en   = 1'b0;
    rx_ready = 1'b0;

    // bytes_in_frame saturates at 255, then restarts on the next frame
    half     = 2;
    rx_ready = 1'b1;
    spi_ss   = 1'b0;
    for (int i = 0; i < 257; i++) send_bits(32'(i), 8);
    tick(half);
    spi_ss = 1'b1;
    tick(12);
    rx_ready = 1'b0;
    check("sat_bytes", 32'(bytes_in_frame), 32'hFF);
    check("sat_overrun", 32'(overrun), 32'h0);
    half = 4;
    frame(32'hC3, 8);
    check("sat_restart_bytes", 32'(bytes_in_frame), 32'h1);
    check("sat_restart_data", 32'(rx_data), 32'hC3);
    accept();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
